// File: rtl/label_union_find_engine.sv
// Union-find responder for connected-component labeling: pops find/union requests,
// walks an internal parent table to the root and answers with a one-cycle done pulse.
//   state | meaning
//   CLEAR | parent[i]=i written one entry per cycle
//   IDLE  | waiting for a request
//   FIND1 | walking node1 to its root
//   FIND2 | walking node2 to its root (union only)
//   LINK  | attach larger root under smaller root
//   RESP  | done pulse with result
module label_union_find_engine #(
  parameter int N          = 256,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            req_op,
  input  logic [ADDR_WIDTH-1:0] req_node1,
  input  logic [ADDR_WIDTH-1:0] req_node2,
  output logic                  rsp_valid,
  output logic [ADDR_WIDTH-1:0] rsp_result,
  output logic                  busy,
  output logic                  err
);

  typedef enum logic [2:0] {
    S_CLEAR, S_IDLE, S_FIND1, S_FIND2, S_LINK, S_RESP
  } state_t;

  state_t state, state_nxt;

  logic [ADDR_WIDTH-1:0] parent [N];
  logic [ADDR_WIDTH-1:0] idx, cur, r1, r2, node2_q;
  logic [ADDR_WIDTH:0]   hops;
  logic                  is_union;

  logic [ADDR_WIDTH-1:0] par_cur, node1_eff, node2_eff, link_lo, link_hi, link_res;
  logic                  at_root, hop_tc, walk_done, accept, node1_ok, node2_ok;
  logic                  link_we, tbl_we;
  logic [ADDR_WIDTH-1:0] tbl_waddr, tbl_wdata;

  assign par_cur   = parent[cur];
  assign at_root   = (par_cur == cur);
  assign hop_tc    = (hops == '0);
  assign walk_done = at_root || hop_tc;
  assign accept    = req_valid && req_ready;

  // Out-of-range labels collapse onto background label 0.
  assign node1_ok  = ({1'b0, req_node1} < (ADDR_WIDTH+1)'(N));
  assign node2_ok  = ({1'b0, req_node2} < (ADDR_WIDTH+1)'(N));
  assign node1_eff = node1_ok ? req_node1 : '0;
  assign node2_eff = node2_ok ? req_node2 : '0;

  assign link_lo  = (r1 < r2) ? r1 : r2;
  assign link_hi  = (r1 < r2) ? r2 : r1;
  assign link_we  = (state == S_LINK) && (r1 != r2) && (r1 != '0) && (r2 != '0);
  assign link_res = (r1 == '0) ? r2 : ((r2 == '0) ? r1 : link_lo);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_CLEAR;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    busy      = (state != S_IDLE);
    case (state)
      S_CLEAR: if (idx == ADDR_WIDTH'(N-1)) state_nxt = S_IDLE;
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = (req_op == 2'b00) ? S_RESP : S_FIND1;
      end
      S_FIND1: if (walk_done) state_nxt = is_union ? S_FIND2 : S_RESP;
      S_FIND2: if (walk_done) state_nxt = S_LINK;
      S_LINK:  state_nxt = S_RESP;
      S_RESP: begin
        rsp_valid = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_CLEAR;
    endcase
    // clear aborts anything in flight, including a pending done pulse
    if (clear) begin
      state_nxt = S_CLEAR;
      req_ready = 1'b0;
      rsp_valid = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx        <= '0;
      cur        <= '0;
      r1         <= '0;
      r2         <= '0;
      node2_q    <= '0;
      hops       <= '0;
      is_union   <= 1'b0;
      err        <= 1'b0;
      rsp_result <= '0;
    end else if (clear) begin
      idx <= '0;
      err <= 1'b0;
    end else begin
      case (state)
        S_CLEAR: idx <= idx + 1'b1;
        S_IDLE: if (accept) begin
          is_union <= req_op[0];
          cur      <= node1_eff;
          node2_q  <= node2_eff;
          hops     <= (ADDR_WIDTH+1)'(N);
          if (req_op == 2'b00) rsp_result <= '0;
          if (((req_op != 2'b00) && !node1_ok) || (req_op[0] && !node2_ok)) err <= 1'b1;
        end
        S_FIND1: if (walk_done) begin
          r1   <= cur;
          cur  <= node2_q;
          hops <= (ADDR_WIDTH+1)'(N);
          if (!at_root) err <= 1'b1;
          if (!is_union) rsp_result <= cur;
        end else begin
          cur  <= par_cur;
          hops <= hops - 1'b1;
        end
        S_FIND2: if (walk_done) begin
          r2 <= cur;
          if (!at_root) err <= 1'b1;
        end else begin
          cur  <= par_cur;
          hops <= hops - 1'b1;
        end
        S_LINK:  rsp_result <= link_res;
        default: ;
      endcase
    end
  end

  always_comb begin
    tbl_we    = 1'b0;
    tbl_waddr = idx;
    tbl_wdata = idx;
    if (!clear) begin
      if (state == S_CLEAR) begin
        tbl_we = 1'b1;
      end else if (link_we) begin
        tbl_we    = 1'b1;
        tbl_waddr = link_hi;
        tbl_wdata = link_lo;
      end
    end
  end

  // Table storage is deliberately not reset; CLEAR initialises it.
  always_ff @(posedge clk) begin
    if (tbl_we) parent[tbl_waddr] <= tbl_wdata;
  end

endmodule

// File: doc/label_union_find_engine.md
Name: label_union_find_engine

Overview:
- Responder side of the labeling find/union request FIFO.
- Pops one {op, node1, node2} request at a time, resolves label equivalences in an internal parent table, and returns a root label with a one-cycle done pulse.
- Sits between the request FIFO read port and the labeling pass that consumes resolved labels.
- The table is re-initialised at every frame start via `clear`.

Parameters:
- N, 256, number of label entries in the parent table (labels 0..N-1).
- ADDR_WIDTH, 8, label width; N <= 2**ADDR_WIDTH.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous table re-init request (pulse at frame start).
- req_valid  in  1  request present (FIFO not empty).
- req_ready  out  1  engine can accept a request this cycle (drives FIFO rd_en together with req_valid).
- req_op  in  2  operation; bit1 = find, bit0 = union.
- req_node1  in  ADDR_WIDTH  first label.
- req_node2  in  ADDR_WIDTH  second label (union only).
- rsp_valid  out  1  one-cycle done pulse.
- rsp_result  out  ADDR_WIDTH  resolved root label, held until next rsp_valid.
- busy  out  1  high in any state except IDLE.
- err  out  1  sticky error flag, cleared only by reset or clear.

Behaviour:
- Reset values: req_ready=0, rsp_valid=0, rsp_result=0, busy=1, err=0.
- After reset release the FSM enters CLEAR; the table array itself is not async-reset.
- States: CLEAR, IDLE, FIND1, FIND2, LINK, RESP.
- CLEAR:
  - Writes parent[i]=i for one index per cycle, i=0..N-1, so it lasts N cycles.
  - Then goes to IDLE.
  - req_ready=0 throughout.
- IDLE:
  - req_ready=1.
  - Accept when req_valid&&req_ready; latch op, node1 and node2.
  - op 2'b00: no table access, straight to RESP, rsp_result=0.
  - op 2'b10 (find): go to FIND1.
  - op 2'b01 and 2'b11 (union; union has priority): go to FIND1, then FIND2.
- FIND1/FIND2:
  - One table read per cycle with cur<=parent[cur].
  - Root is reached when parent[cur]==cur; the state then exits.
  - No path compression.
  - A hop counter resets per walk.
  - If the counter reaches N with no root found: set err, take the current cur as the root, and exit normally.
- LINK (one cycle):
  - r1/r2 are the roots from FIND1/FIND2.
  - If r1==r2, or either is 0: no write.
  - Otherwise parent[max(r1,r2)]<=min(r1,r2).
  - Result = min(nonzero roots); 0 if both are 0.
- RESP:
  - rsp_valid=1 for exactly one cycle and rsp_result is updated.
  - Returns to IDLE.
- Find result is the root of node1.
- Latency, with the accept cycle = T and d = hops to the root:
  - Find: rsp_valid at T+2+d.
  - Union: rsp_valid at T+4+d1+d2.
  - Nop: rsp_valid at T+1.
- One request in flight; req_ready=0 from the cycle after accept until the cycle after RESP.
- There is no response backpressure.
- Label 0 is background: parent[0]=0 always and is never written.
- Node >= N (when N<2**ADDR_WIDTH): set err; treat the node as label 0.
- clear:
  - Legal in any state; it aborts the in-flight request with no rsp_valid.
  - Enters CLEAR on the next cycle and clears err.
  - clear during CLEAR restarts the index at 0.
- Async reset mid-operation: outputs return to reset values immediately and the FSM goes to CLEAR.
- Simultaneous clear and req_valid in IDLE: clear wins and no request is accepted.

Test Plan:
- Reset release -> busy=1 and req_ready=0 for 256 cycles; then req_ready=1, err=0.
- Find(5) on a fresh table -> rsp_valid at T+2 with rsp_result=5; no other rsp_valid pulses.
- Union(7,3), then union(9,7), then find(9):
  - the first union returns 3 at T+4;
  - find(9) returns 3 with d=1, i.e. at T+3.
- Union(0,12) -> result 12, no table write; a subsequent find(12) -> 12.
- Back-to-back requests with req_valid held high -> exactly one accept per request, req_ready low while busy, results in order.
- clear asserted during FIND2 of a pending union -> no rsp_valid, 256-cycle CLEAR, then find(9) -> 9.
